coletor_jogada: RTL and testbench
=================================

// Module: coletor_jogada
// PURPOSE
// - Input sequencer in front of the move register. Collects one chess move from the board
//   interface as two square strobes: origin, then destination.
// - Enforces an inter-square timeout and a cancel action.
// - Presents the finished move to the game control unit with temJogada, a level held until
//   the control unit signals consumption (its registraR).
// PARAMETERS
// - LARGURA_CASA   6         square index width (0..63, a1=0, h8=63)
// - TIMEOUT_CICLOS 50000000  max cycles allowed between origin and destination strobes (>=2)
// PORTS
// - clock       in   1   system clock; all state updates on rising edge
// - reset       in   1   asynchronous, active-high; returns block to ocioso
// - habilita    in   1   collection allowed (driven by control unit contaT)
// - casa_pulso  in   1   one-cycle strobe: casa is valid this cycle
// - casa        in   6   square index qualified by casa_pulso
// - cancela     in   1   drop the selected origin (level, sampled each cycle)
// - consumida   in   1   one-cycle pulse: datapath has registered the move
// - temJogada   out  1   move ready; high only in state pronta
// - origem      out  6   registered origin square
// - destino     out  6   registered destination square
// - erro        out  1   one-cycle pulse on timeout
// - db_estado   out  4   current state encoding for 7-seg debug
// BEHAVIOUR
// - Reset values: state=ocioso, temJogada=0, origem=0, destino=0, erro=0, timeout counter=0.
// - Reset mid-operation: any partial or pending move is discarded immediately.
// - Moore outputs decoded from state: temJogada, erro, db_estado.
// - origem and destino are registers. Each is written only on a capture. Each holds its value
//   otherwise, including across cancel and timeout.
// - States (db_estado): ocioso=0, espera_origem=1, espera_destino=2, pronta=5, erro_t=E.
// - Global rule: habilita=0 in any state -> ocioso next cycle. A pending temJogada drops.
// - ocioso:
//   - habilita=1 -> espera_origem.
// - espera_origem:
//   - casa_pulso -> origem<=casa, counter<=0, go to espera_destino.
//   - cancela in this state: ignored.
// - espera_destino. Priority order:
//   1) cancela -> espera_origem.
//   2) casa_pulso with casa==origem -> deselect, espera_origem, no erro.
//   3) casa_pulso with casa!=origem -> destino<=casa, go to pronta.
//   4) counter==TIMEOUT_CICLOS-1 -> erro_t.
//   5) otherwise counter++.
//   - A strobe arriving on the timeout cycle wins: the move is accepted.
// - pronta:
//   - temJogada=1.
//   - casa_pulso and cancela ignored. origem and destino frozen.
//   - consumida -> espera_origem. temJogada low the next cycle.
// - erro_t: erro=1 for exactly one cycle, then espera_origem.
// - Latency: destination strobe at cycle N -> temJogada=1 at N+1.
// - Counter width: $clog2(TIMEOUT_CICLOS). Cleared on entry to espera_destino. Never wraps:
//   leaving the state at terminal count is mandatory.
// - Unused state encodings -> ocioso (default branch).
// STRUCTURE
// - Shared package/include (jogo_defs.vh):
//   - LARGURA_CASA
//   - state encodings above, so control unit and debug decoders agree
// - Sub-module contador_timeout: parameterised up-counter with zera, conta and fim outputs;
//   fim asserted at TIMEOUT_CICLOS-1. Reused by the game timer.
// - FSM, capture registers and output decode stay in this module.
// TESTING (TIMEOUT_CICLOS=8 in bench)
// - Basic move:
//   - habilita=1; strobe casa=12, then casa=28 three cycles later.
//   - Expect temJogada=1 one cycle after the 2nd strobe, origem=12, destino=28.
//   - consumida pulse -> temJogada=0 the next cycle, state=1.
// - Timeout:
//   - strobe casa=5; no further strobe.
//   - Expect erro=1 for exactly one cycle, eight cycles after entering state 2, then state=1.
//   - origem stays 5.
// - Deselect and cancel:
//   - casa=9 then casa=9 -> state=1, erro=0, temJogada=0.
//   - casa=9 then cancela=1 together with casa_pulso (casa=17) -> cancel wins, destino unchanged.
// - Hold in pronta:
//   - move 1->2 pending; strobe casa=40 and raise cancela.
//   - Expect origem=1, destino=2, temJogada=1 until consumida.
// - Disable and reset:
//   - habilita=0 while in state 2 -> state 0 next cycle.
//   - async reset asserted in pronta mid-cycle -> temJogada=0, origem=0, destino=0 immediately.
// - Boundary:
//   - strobe on the timeout cycle (casa=63 at count 7) -> move accepted, erro=0.

Source files
------------

// File: rtl/coletor_jogada_pkg.sv
// rtl/coletor_jogada_pkg.sv - shared square width and state encodings for the move collector
package coletor_jogada_pkg;

  localparam int LARGURA_CASA = 6;

  // Encodings are shared with the control unit and the 7-segment debug decoder
  typedef enum logic [3:0] {
    OCIOSO         = 4'h0,
    ESPERA_ORIGEM  = 4'h1,
    ESPERA_DESTINO = 4'h2,
    PRONTA         = 4'h5,
    ERRO_T         = 4'hE
  } estado_t;

endpackage

// File: rtl/coletor_jogada_contador_timeout.sv
// rtl/coletor_jogada_contador_timeout.sv - saturating up-counter flagging the last allowed cycle
module contador_timeout #(
  parameter int TIMEOUT_CICLOS = 50000000,
  localparam int LARGURA = $clog2(TIMEOUT_CICLOS)
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  logic [LARGURA-1:0] valor;

  // Count holds at the terminal value; the owner must leave its wait state there
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valor <= '0;
    end else if (zera) begin
      valor <= '0;
    end else if (conta && !fim) begin
      valor <= valor + 1'b1;
    end
  end

  assign fim = (valor == LARGURA'(TIMEOUT_CICLOS - 1));

endmodule

// File: rtl/coletor_jogada.sv
// rtl/coletor_jogada.sv - collects an origin/destination square pair into one move
module coletor_jogada
  import coletor_jogada_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 50000000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    habilita,
  input  logic                    casa_pulso,
  input  logic [LARGURA_CASA-1:0] casa,
  input  logic                    cancela,
  input  logic                    consumida,
  output logic                    temJogada,
  output logic [LARGURA_CASA-1:0] origem,
  output logic [LARGURA_CASA-1:0] destino,
  output logic                    erro,
  output logic [3:0]              db_estado
);

  estado_t estado, estadoProx;
  logic    capturaOrigem, capturaDestino;
  logic    contaTempo, fimTempo;

  contador_timeout #(
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
  ) uContador (
    .clock (clock),
    .reset (reset),
    .zera  (capturaOrigem),
    .conta (contaTempo),
    .fim   (fimTempo)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= estadoProx;
    end
  end

  // Next state and capture strobes; losing habilita aborts from any state
  always_comb begin
    estadoProx     = estado;
    capturaOrigem  = 1'b0;
    capturaDestino = 1'b0;
    contaTempo     = 1'b0;
    if (!habilita) begin
      estadoProx = OCIOSO;
    end else begin
      unique case (estado)
        OCIOSO: estadoProx = ESPERA_ORIGEM;
        ESPERA_ORIGEM: begin
          if (casa_pulso) begin
            capturaOrigem = 1'b1;
            estadoProx    = ESPERA_DESTINO;
          end
        end
        ESPERA_DESTINO: begin
          // A strobe on the terminal cycle still beats the timeout
          if (cancela) begin
            estadoProx = ESPERA_ORIGEM;
          end else if (casa_pulso && (casa == origem)) begin
            estadoProx = ESPERA_ORIGEM;
          end else if (casa_pulso) begin
            capturaDestino = 1'b1;
            estadoProx     = PRONTA;
          end else if (fimTempo) begin
            estadoProx = ERRO_T;
          end else begin
            contaTempo = 1'b1;
          end
        end
        PRONTA: begin
          if (consumida) begin
            estadoProx = ESPERA_ORIGEM;
          end
        end
        ERRO_T: estadoProx = ESPERA_ORIGEM;
        default: estadoProx = OCIOSO;
      endcase
    end
  end

  // Square registers change only on a capture and survive cancel and timeout
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      origem  <= '0;
      destino <= '0;
    end else begin
      if (capturaOrigem) begin
        origem <= casa;
      end
      if (capturaDestino) begin
        destino <= casa;
      end
    end
  end

  assign temJogada = (estado == PRONTA);
  assign erro      = (estado == ERRO_T);
  assign db_estado = estado;

endmodule

// File: tb/tb_coletor_jogada.sv
// tb/tb_coletor_jogada.sv - randomized and directed checks of coletor_jogada against a move model
module tb_coletor_jogada;
  import coletor_jogada_pkg::*;

  localparam int T = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       habilita, casa_pulso, cancela, consumida;
  logic [5:0] casa;
  logic       temJogada, erro;
  logic [5:0] origem, destino;
  logic [3:0] db_estado;

  int passou = 0;
  int total  = 0;

  // Reference model: phase code, captured squares, edge count and origin timestamp
  int mFase, mOrigem, mDestino, ciclo, entrada;

  coletor_jogada #(.TIMEOUT_CICLOS(T)) dut (
    .clock      (clock),
    .reset      (reset),
    .habilita   (habilita),
    .casa_pulso (casa_pulso),
    .casa       (casa),
    .cancela    (cancela),
    .consumida  (consumida),
    .temJogada  (temJogada),
    .origem     (origem),
    .destino    (destino),
    .erro       (erro),
    .db_estado  (db_estado)
  );

  always #5 clock = ~clock;

  task automatic confere(input string tag, input int obs, input int esp);
    total++;
    if (obs == esp) passou++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
  endtask

  task automatic modeloReset();
    mFase = 0; mOrigem = 0; mDestino = 0; entrada = 0;
  endtask

  // One rising edge of the move-collection rules, using the inputs currently driven
  task automatic modeloAtualiza();
    ciclo++;
    if (!habilita) mFase = 0;
    else begin
      case (mFase)
        0: mFase = 1;
        1: if (casa_pulso) begin mOrigem = casa; entrada = ciclo; mFase = 2; end
        2: begin
          if (cancela) mFase = 1;
          else if (casa_pulso && casa == mOrigem) mFase = 1;
          else if (casa_pulso) begin mDestino = casa; mFase = 5; end
          else if (ciclo - entrada == T) mFase = 14;
        end
        5: if (consumida) mFase = 1;
        default: mFase = 1;
      endcase
    end
  endtask

  task automatic confereModelo(input string ctx);
    confere({ctx, ".estado"}, db_estado, mFase);
    confere({ctx, ".temJogada"}, temJogada, (mFase == 5) ? 1 : 0);
    confere({ctx, ".erro"}, erro, (mFase == 14) ? 1 : 0);
    confere({ctx, ".origem"}, origem, mOrigem);
    confere({ctx, ".destino"}, destino, mDestino);
  endtask

  // Drive one cycle of inputs from a falling edge, then check on the next falling edge
  task automatic passo(input string ctx, input logic h, input logic p, input int c,
                       input logic k, input logic u);
    habilita = h; casa_pulso = p; casa = c[5:0]; cancela = k; consumida = u;
    @(posedge clock);
    modeloAtualiza();
    @(negedge clock);
    confereModelo(ctx);
  endtask

  initial begin
    reset = 1'b1; habilita = 0; casa_pulso = 0; casa = 0; cancela = 0; consumida = 0;
    ciclo = 0;
    modeloReset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    confereModelo("reset");

    // Basic move
    passo("hab", 1, 0, 0, 0, 0);
    confere("basico.estado1", db_estado, 1);
    passo("org12", 1, 1, 12, 0, 0);
    passo("idle", 1, 0, 0, 0, 0);
    passo("idle", 1, 0, 0, 0, 0);
    passo("dst28", 1, 1, 28, 0, 0);
    confere("basico.temJogada", temJogada, 1);
    confere("basico.origem", origem, 12);
    confere("basico.destino", destino, 28);
    passo("consumida", 1, 0, 0, 0, 1);
    confere("basico.consumida.temJogada", temJogada, 0);
    confere("basico.consumida.estado", db_estado, 1);

    // Timeout: erro exactly on the eighth cycle after entering state 2
    passo("org5", 1, 1, 5, 0, 0);
    for (int k = 1; k <= T; k++) begin
      passo("timeout.espera", 1, 0, 0, 0, 0);
      confere($sformatf("timeout.erro%0d", k), erro, (k == T) ? 1 : 0);
    end
    passo("timeout.volta", 1, 0, 0, 0, 0);
    confere("timeout.estado", db_estado, 1);
    confere("timeout.origem", origem, 5);

    // Deselect by repeating the origin
    passo("org9", 1, 1, 9, 0, 0);
    passo("desel9", 1, 1, 9, 0, 0);
    confere("desel.estado", db_estado, 1);
    confere("desel.erro", erro, 0);
    confere("desel.temJogada", temJogada, 0);

    // Cancel beats a simultaneous strobe
    passo("org9b", 1, 1, 9, 0, 0);
    passo("cancela17", 1, 1, 17, 1, 0);
    confere("cancela.estado", db_estado, 1);
    confere("cancela.destino", destino, 28);

    // Pending move ignores strobes and cancel
    passo("org1", 1, 1, 1, 0, 0);
    passo("dst2", 1, 1, 2, 0, 0);
    for (int k = 0; k < 3; k++) begin
      passo("pronta.ruido", 1, 1, 40, 1, 0);
      confere("pronta.origem", origem, 1);
      confere("pronta.destino", destino, 2);
      confere("pronta.temJogada", temJogada, 1);
    end
    passo("pronta.consumida", 1, 0, 0, 0, 1);
    confere("pronta.fim", temJogada, 0);

    // Disable while waiting for destination
    passo("org7", 1, 1, 7, 0, 0);
    passo("desabilita", 0, 0, 0, 0, 0);
    confere("desabilita.estado", db_estado, 0);

    // Strobe on the terminal timeout cycle is accepted
    passo("hab2", 1, 0, 0, 0, 0);
    passo("org3", 1, 1, 3, 0, 0);
    for (int k = 0; k < T - 1; k++) passo("limite.espera", 1, 0, 0, 0, 0);
    passo("limite.dst63", 1, 1, 63, 0, 0);
    confere("limite.temJogada", temJogada, 1);
    confere("limite.erro", erro, 0);
    confere("limite.destino", destino, 63);

    // Asynchronous reset while a move is pending
    #2 reset = 1'b1;
    #1;
    confere("resetAsync.temJogada", temJogada, 0);
    confere("resetAsync.origem", origem, 0);
    confere("resetAsync.destino", destino, 0);
    modeloReset();
    @(negedge clock);
    reset = 1'b0;
    confereModelo("resetAsync");

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      int c;
      c = (($urandom_range(0, 3) == 0) ? mOrigem : $urandom_range(0, 63));
      passo("aleatorio",
            ($urandom_range(0, 99) < 96) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 22) ? 1'b1 : 1'b0,
            c,
            ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0);
    end

    $display("%0d/%0d checks passed", passou, total);
    $finish;
  end

endmodule
